// File: rtl/mccpu_ctrl.sv
// Purpose: multi-cycle FSM control unit for the MIPS-subset CPU; drives all datapath enables/selects, traps illegal encodings, counts retired instructions.
// Latency: j/jal/jr/jalr 2 cycles, beq/bne 3, ALU 4, sw 3+W, lw 4+W (W = MEM cycles, at least 1).
// Backpressure: MEM holds until mem_ready (USE_READY=1) or a fixed MEM_LAT-cycle count (USE_READY=0); enables gated off while rst is high.
module mccpu_ctrl #(
    parameter int USE_READY = 1,
    parameter int MEM_LAT   = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             EXTOp,
    output logic             ALUSrc,
    output logic             ALU_A,
    output logic [3:0]       ALUOp,
    output logic [1:0]       NPCOp,
    output logic [1:0]       GPRSel,
    output logic [1:0]       WDSel,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    localparam int WC_W = $clog2(MEM_LAT) + 1;
    localparam logic [WC_W-1:0] LAT_M1 = WC_W'(MEM_LAT - 1);

    localparam logic [3:0] A_NOP = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3,
                           A_OR  = 4'd4, A_SLT = 4'd5, A_SLTU = 4'd6, A_NOR = 4'd7,
                           A_SLL = 4'd8, A_SRL = 4'd9, A_LUI = 4'd10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t          state_q, state_nxt;
    logic [WC_W-1:0] wcnt;
    logic            legal, is_j, is_jal, is_jr, is_jalr, is_beq, is_bne, is_lw, is_sw, is_ialu;
    logic [3:0]      d_aluop;
    logic            d_alusrc, d_alua, d_extop;
    logic            mem_done;

    assign state    = state_q;
    assign mem_done = (USE_READY != 0) ? mem_ready : (wcnt == LAT_M1);

    // Instruction decode: legality, class flags and the ALU control word used in EXEC/MEM/WB.
    always_comb begin
        legal = 1'b0; is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0; is_jalr = 1'b0;
        is_beq = 1'b0; is_bne = 1'b0; is_lw = 1'b0; is_sw = 1'b0; is_ialu = 1'b0;
        d_aluop = A_NOP; d_alusrc = 1'b0; d_alua = 1'b0; d_extop = 1'b0;
        case (Op)
            6'b000000: begin
                legal = 1'b1;
                case (Funct)
                    6'b100000, 6'b100001: d_aluop = A_ADD;
                    6'b100010, 6'b100011: d_aluop = A_SUB;
                    6'b100100: d_aluop = A_AND;
                    6'b100101: d_aluop = A_OR;
                    6'b100111: d_aluop = A_NOR;
                    6'b101010: d_aluop = A_SLT;
                    6'b101011: d_aluop = A_SLTU;
                    6'b000000: begin d_aluop = A_SLL; d_alua = 1'b1; end
                    6'b000010: begin d_aluop = A_SRL; d_alua = 1'b1; end
                    6'b000100: d_aluop = A_SLL;
                    6'b000110: d_aluop = A_SRL;
                    6'b001000: is_jr = 1'b1;
                    6'b001001: is_jalr = 1'b1;
                    default:   legal = 1'b0;
                endcase
            end
            6'b001000: begin legal = 1'b1; is_ialu = 1'b1; d_aluop = A_ADD; d_alusrc = 1'b1; d_extop = 1'b1; end
            6'b001100: begin legal = 1'b1; is_ialu = 1'b1; d_aluop = A_AND; d_alusrc = 1'b1; end
            6'b001101: begin legal = 1'b1; is_ialu = 1'b1; d_aluop = A_OR;  d_alusrc = 1'b1; end
            6'b001010: begin legal = 1'b1; is_ialu = 1'b1; d_aluop = A_SLT; d_alusrc = 1'b1; d_extop = 1'b1; end
            6'b001111: begin legal = 1'b1; is_ialu = 1'b1; d_aluop = A_LUI; d_alusrc = 1'b1; end
            6'b100011: begin legal = 1'b1; is_lw = 1'b1; d_aluop = A_ADD; d_alusrc = 1'b1; d_extop = 1'b1; end
            6'b101011: begin legal = 1'b1; is_sw = 1'b1; d_aluop = A_ADD; d_alusrc = 1'b1; d_extop = 1'b1; end
            6'b000100: begin legal = 1'b1; is_beq = 1'b1; d_aluop = A_SUB; end
            6'b000101: begin legal = 1'b1; is_bne = 1'b1; d_aluop = A_SUB; end
            6'b000010: begin legal = 1'b1; is_j = 1'b1; end
            6'b000011: begin legal = 1'b1; is_jal = 1'b1; end
            default:   legal = 1'b0;
        endcase
    end

    // Next-state and control outputs; enables are forced low while rst is asserted.
    always_comb begin
        state_nxt = state_q;
        PCWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        EXTOp = 1'b0; ALUSrc = 1'b0; ALU_A = 1'b0; ALUOp = A_NOP;
        NPCOp = 2'd0; GPRSel = 2'd0; WDSel = 2'd0; illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite = 1'b1; PCWrite = 1'b1; NPCOp = 2'd0;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (!legal) begin
                    state_nxt = S_TRAP;
                end else if (is_j || is_jal) begin
                    PCWrite = 1'b1; NPCOp = 2'd2;
                    if (is_jal) begin RegWrite = 1'b1; GPRSel = 2'd2; WDSel = 2'd2; end
                    state_nxt = S_FETCH;
                end else if (is_jr || is_jalr) begin
                    PCWrite = 1'b1; NPCOp = 2'd3;
                    if (is_jalr) begin RegWrite = 1'b1; GPRSel = 2'd0; WDSel = 2'd2; end
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                ALUOp = d_aluop; ALUSrc = d_alusrc; ALU_A = d_alua; EXTOp = d_extop;
                if (is_beq || is_bne) begin
                    PCWrite   = (is_beq & Zero) | (is_bne & ~Zero);
                    NPCOp     = 2'd1;
                    state_nxt = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                ALUOp = d_aluop; ALUSrc = d_alusrc; ALU_A = d_alua; EXTOp = d_extop;
                MemRead  = is_lw;
                MemWrite = is_sw;
                if (mem_done) state_nxt = is_lw ? S_WB : S_FETCH;
            end
            S_WB: begin
                ALUOp = d_aluop; ALUSrc = d_alusrc; ALU_A = d_alua; EXTOp = d_extop;
                RegWrite = 1'b1;
                if (is_lw) begin
                    WDSel = 2'd1; GPRSel = 2'd1;
                end else if (is_ialu) begin
                    WDSel = 2'd0; GPRSel = 2'd1;
                end
                state_nxt = S_FETCH;
            end
            S_TRAP: illegal = 1'b1;
            default: state_nxt = S_FETCH;
        endcase
        if (rst) begin
            PCWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        end
    end

    // State register, MEM wait counter (zero outside MEM) and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wcnt    <= '0;
            retired <= '0;
        end else begin
            state_q <= state_nxt;
            wcnt    <= (state_q == S_MEM) ? wcnt + WC_W'(1) : '0;
            if (state_q != S_FETCH && state_q != S_TRAP && state_nxt == S_FETCH)
                retired <= retired + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mccpu_ctrl.sv
// Purpose: directed self-checking bench for mccpu_ctrl (handshake and fixed-latency MEM variants).
// Latency: checks every cycle of each instruction sequence against hand-computed values.
// Backpressure: mem_ready held low/high to stretch or end MEM; rst pulsed mid-store.
module tb_mccpu_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Variant A: USE_READY=1
    logic        rst, zero, mem_ready;
    logic [5:0]  op, funct;
    logic        pcw, irw, rgw, mw, mr, extop, alusrc, alua, ill;
    logic [3:0]  aluop;
    logic [1:0]  npcop, gprsel, wdsel;
    logic [2:0]  st;
    logic [31:0] ret;

    // Variant B: USE_READY=0, MEM_LAT=3
    logic        rst2;
    logic [5:0]  op2;
    logic        pcw2, irw2, rgw2, mw2, mr2, extop2, alusrc2, alua2, ill2;
    logic [3:0]  aluop2;
    logic [1:0]  npcop2, gprsel2, wdsel2;
    logic [2:0]  st2;
    logic [31:0] ret2;

    int errors = 0;
    int checks = 0;

    mccpu_ctrl #(.USE_READY(1), .MEM_LAT(1), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .Op(op), .Funct(funct), .Zero(zero), .mem_ready(mem_ready),
        .PCWrite(pcw), .IRWrite(irw), .RegWrite(rgw), .MemWrite(mw), .MemRead(mr),
        .EXTOp(extop), .ALUSrc(alusrc), .ALU_A(alua), .ALUOp(aluop), .NPCOp(npcop),
        .GPRSel(gprsel), .WDSel(wdsel), .state(st), .illegal(ill), .retired(ret)
    );

    mccpu_ctrl #(.USE_READY(0), .MEM_LAT(3), .CNT_W(32)) dut2 (
        .clk(clk), .rst(rst2), .Op(op2), .Funct(6'd0), .Zero(1'b0), .mem_ready(1'b1),
        .PCWrite(pcw2), .IRWrite(irw2), .RegWrite(rgw2), .MemWrite(mw2), .MemRead(mr2),
        .EXTOp(extop2), .ALUSrc(alusrc2), .ALU_A(alua2), .ALUOp(aluop2), .NPCOp(npcop2),
        .GPRSel(gprsel2), .WDSel(wdsel2), .state(st2), .illegal(ill2), .retired(ret2)
    );

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                           OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                           OP_JAL = 6'b000011, OP_BAD = 6'b111111;

    // Enable vector {PCWrite, IRWrite, RegWrite, MemWrite, MemRead}
    function automatic logic [31:0] en_a();
        return 32'({pcw, irw, rgw, mw, mr});
    endfunction
    function automatic logic [31:0] en_b();
        return 32'({pcw2, irw2, rgw2, mw2, mr2});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; rst2 = 1'b0; op = OP_R; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0; op2 = OP_R;
        #1 rst = 1'b1; rst2 = 1'b1;
        tick(); #1;
        chk("rst_state", 32'(st), 0); chk("rst_retired", ret, 0);
        chk("rst_illegal", 32'(ill), 0); chk("rst_enables", en_a(), 0);

        // addi $1,$0,5
        tick(); rst = 1'b0; op = OP_ADDI; #1;
        chk("addi_F_state", 32'(st), 0); chk("addi_F_en", en_a(), 'b11000); chk("addi_F_npc", 32'(npcop), 0);
        tick(); #1;
        chk("addi_D_state", 32'(st), 1); chk("addi_D_en", en_a(), 0);
        tick(); #1;
        chk("addi_E_state", 32'(st), 2); chk("addi_E_aluop", 32'(aluop), 1);
        chk("addi_E_ext", 32'(extop), 1); chk("addi_E_src", 32'(alusrc), 1); chk("addi_E_en", en_a(), 0);
        tick(); #1;
        chk("addi_W_state", 32'(st), 4); chk("addi_W_en", en_a(), 'b00100);
        chk("addi_W_gpr", 32'(gprsel), 1); chk("addi_W_wd", 32'(wdsel), 0); chk("addi_W_aluop", 32'(aluop), 1);

        // lw with mem_ready pulses outside MEM, then 2 wait cycles
        tick(); op = OP_LW; mem_ready = 1'b0; #1;
        chk("lw_F_state", 32'(st), 0); chk("addi_retired", ret, 1);
        tick(); mem_ready = 1'b1; #1;
        chk("lw_D_state", 32'(st), 1);
        tick(); mem_ready = 1'b1; #1;
        chk("lw_E_state", 32'(st), 2); chk("lw_E_aluop", 32'(aluop), 1); chk("lw_E_src", 32'(alusrc), 1);
        tick(); mem_ready = 1'b0; #1;
        chk("lw_M1_state", 32'(st), 3); chk("lw_M1_en", en_a(), 'b00001);
        tick(); mem_ready = 1'b0; #1;
        chk("lw_M2_state", 32'(st), 3); chk("lw_M2_en", en_a(), 'b00001);
        tick(); mem_ready = 1'b1; #1;
        chk("lw_M3_state", 32'(st), 3); chk("lw_M3_en", en_a(), 'b00001);
        tick(); mem_ready = 1'b0; #1;
        chk("lw_W_state", 32'(st), 4); chk("lw_W_en", en_a(), 'b00100);
        chk("lw_W_wd", 32'(wdsel), 1); chk("lw_W_gpr", 32'(gprsel), 1);

        // beq taken
        tick(); op = OP_BEQ; #1;
        chk("beq1_F_state", 32'(st), 0); chk("lw_retired", ret, 2);
        tick(); #1;
        chk("beq1_D_state", 32'(st), 1);
        tick(); zero = 1'b1; #1;
        chk("beq1_E_state", 32'(st), 2); chk("beq1_E_en", en_a(), 'b10000);
        chk("beq1_E_npc", 32'(npcop), 1); chk("beq1_E_aluop", 32'(aluop), 2);
        // beq not taken
        tick(); zero = 1'b0; #1;
        chk("beq2_F_state", 32'(st), 0); chk("beq1_retired", ret, 3);
        tick(); #1;
        tick(); zero = 1'b0; #1;
        chk("beq2_E_state", 32'(st), 2); chk("beq2_E_en", en_a(), 0);
        // bne taken on Zero=0
        tick(); op = OP_BNE; #1;
        chk("bne_F_state", 32'(st), 0); chk("beq2_retired", ret, 4);
        tick(); #1;
        tick(); zero = 1'b0; #1;
        chk("bne_E_state", 32'(st), 2); chk("bne_E_en", en_a(), 'b10000);

        // jal
        tick(); op = OP_JAL; #1;
        chk("jal_F_state", 32'(st), 0); chk("bne_retired", ret, 5);
        tick(); #1;
        chk("jal_D_state", 32'(st), 1); chk("jal_D_en", en_a(), 'b10100);
        chk("jal_D_npc", 32'(npcop), 2); chk("jal_D_gpr", 32'(gprsel), 2); chk("jal_D_wd", 32'(wdsel), 2);

        // illegal opcode traps
        tick(); op = OP_BAD; #1;
        chk("bad_F_state", 32'(st), 0); chk("jal_retired", ret, 6);
        tick(); #1;
        chk("bad_D_state", 32'(st), 1); chk("bad_D_en", en_a(), 0);
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            chk("trap_state", 32'(st), 5); chk("trap_illegal", 32'(ill), 1);
            chk("trap_en", en_a(), 0); chk("trap_retired", ret, 6);
        end
        rst = 1'b1; #1;
        chk("trap_rst_state", 32'(st), 0); chk("trap_rst_illegal", 32'(ill), 0);

        // sll (R-type with shamt)
        tick(); rst = 1'b0; op = OP_R; funct = 6'b000000; #1;
        chk("sll_F_state", 32'(st), 0); chk("sll_F_retired", ret, 0); chk("sll_F_en", en_a(), 'b11000);
        tick(); #1;
        tick(); #1;
        chk("sll_E_state", 32'(st), 2); chk("sll_E_aluop", 32'(aluop), 8);
        chk("sll_E_alua", 32'(alua), 1); chk("sll_E_src", 32'(alusrc), 0);
        tick(); #1;
        chk("sll_W_state", 32'(st), 4); chk("sll_W_en", en_a(), 'b00100); chk("sll_W_gpr", 32'(gprsel), 0);

        // jr
        tick(); funct = 6'b001000; #1;
        chk("jr_F_state", 32'(st), 0); chk("sll_retired", ret, 1);
        tick(); #1;
        chk("jr_D_state", 32'(st), 1); chk("jr_D_en", en_a(), 'b10000); chk("jr_D_npc", 32'(npcop), 3);

        // sw aborted by reset mid-MEM
        tick(); op = OP_SW; mem_ready = 1'b0; #1;
        chk("sw_F_state", 32'(st), 0); chk("jr_retired", ret, 2);
        tick(); #1;
        tick(); #1;
        chk("sw_E_state", 32'(st), 2); chk("sw_E_ext", 32'(extop), 1);
        tick(); #1;
        chk("sw_M1_state", 32'(st), 3); chk("sw_M1_en", en_a(), 'b00010);
        tick(); #1;
        chk("sw_M2_en", en_a(), 'b00010);
        rst = 1'b1; #1;
        chk("sw_rst_en", en_a(), 0); chk("sw_rst_state", 32'(st), 0); chk("sw_rst_retired", ret, 0);
        tick(); rst = 1'b0; op = OP_ADDI; #1;
        chk("post_F_state", 32'(st), 0); chk("post_F_en", en_a(), 'b11000);
        tick(); #1;
        chk("post_D_state", 32'(st), 1);

        // fixed-latency variant: sw with MEM_LAT=3, mem_ready tied high
        tick(); rst2 = 1'b0; op2 = OP_SW; #1;
        chk("b_sw_F_state", 32'(st2), 0); chk("b_sw_F_en", en_b(), 'b11000);
        tick(); #1;
        chk("b_sw_D_state", 32'(st2), 1); chk("b_sw_D_en", en_b(), 0);
        tick(); #1;
        chk("b_sw_E_state", 32'(st2), 2); chk("b_sw_E_en", en_b(), 0);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("b_sw_M_state", 32'(st2), 3); chk("b_sw_M_en", en_b(), 'b00010);
        end
        tick(); #1;
        chk("b_sw_done_state", 32'(st2), 0); chk("b_sw_done_en", en_b(), 'b11000);
        chk("b_sw_retired", ret2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
